// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 raster limits, derived totals and sync window bounds
package vga_timing_pkg;

    // Coordinate width shared by every consumer of pixel_x / pixel_y.
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal timing in pixels.
    localparam int H_DISPLAY = 640;
    localparam int H_FP      = 16;
    localparam int H_RETRACE = 96;
    localparam int H_BP      = 48;

    // Vertical timing in lines.
    localparam int V_DISPLAY = 480;
    localparam int V_FP      = 10;
    localparam int V_RETRACE = 2;
    localparam int V_BP      = 33;

    // Pixel clock divider from the 100 MHz board clock.
    localparam int CLK_DIV = 4;

    // Derived totals.
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_RETRACE + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_RETRACE + V_BP;

    // Sync pulse windows, inclusive on both ends.
    localparam int H_SYNC_START = H_DISPLAY + H_FP;
    localparam int H_SYNC_END   = H_DISPLAY + H_FP + H_RETRACE - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FP;
    localparam int V_SYNC_END   = V_DISPLAY + V_FP + V_RETRACE - 1;

    // True when a coordinate lies inside [lo, hi]; used for the sync windows.
    function automatic logic in_range(input coord_t value, input coord_t lo, input coord_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// rtl/pixel_tick_div.sv - mod-CLK_DIV counter producing a one-clk pixel-rate strobe
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    // Width covers 0..CLK_DIV-1; CLK_DIV is at least 2 so this is never zero.
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Free-running divider, wraps after the last count of each pixel period.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == CNT_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Strobe in the final clk of the pixel period; counters advance on the edge ending it.
    assign p_tick = (div_cnt == CNT_LAST);

endmodule

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - 640x480 raster timing generator (optional frame_tick output: VGA_FRAME_TICK_EN)
module vga_sync #(
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_RETRACE = vga_timing_pkg::H_RETRACE,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_RETRACE = vga_timing_pkg::V_RETRACE,
    parameter int V_BP      = vga_timing_pkg::V_BP,
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
`ifdef VGA_FRAME_TICK_EN
    output logic       frame_tick,
`endif
    output logic [9:0] pixel_y
);

    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::in_range;

    // Derived from this instance's parameters so reduced timings work too.
    localparam int H_TOTAL      = H_DISPLAY + H_FP + H_RETRACE + H_BP;
    localparam int V_TOTAL      = V_DISPLAY + V_FP + V_RETRACE + V_BP;
    localparam int H_SYNC_START = H_DISPLAY + H_FP;
    localparam int H_SYNC_END   = H_DISPLAY + H_FP + H_RETRACE - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FP;
    localparam int V_SYNC_END   = V_DISPLAY + V_FP + V_RETRACE - 1;

    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS_END = coord_t'(V_DISPLAY);
    localparam coord_t H_SS      = coord_t'(H_SYNC_START);
    localparam coord_t H_SE      = coord_t'(H_SYNC_END);
    localparam coord_t V_SS      = coord_t'(V_SYNC_START);
    localparam coord_t V_SE      = coord_t'(V_SYNC_END);

    coord_t h_cnt;
    coord_t v_cnt;
    coord_t h_next;
    coord_t v_next;
    logic   h_end;
    logic   v_end;
    logic   hsync_reg;
    logic   vsync_reg;
    logic   tick;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (tick)
    );

    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);

    // Next-state scan position: hold between ticks, step per tick, wrap line then frame.
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (tick) begin
            if (h_end) begin
                h_next = '0;
                v_next = v_end ? '0 : v_cnt + 1'b1;
            end else begin
                h_next = h_cnt + 1'b1;
            end
        end
    end

    // Scan counters and sync registers; syncs decode next-state so they move with pixel_x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else begin
            h_cnt     <= h_next;
            v_cnt     <= v_next;
            hsync_reg <= ~in_range(h_next, H_SS, H_SE);
            vsync_reg <= ~in_range(v_next, V_SS, V_SE);
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic frame_tick_reg;

    // One-clk pulse following the edge that enters vertical blanking at (0, V_DISPLAY).
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= tick && h_end && (v_cnt == V_VIS_END - 1'b1);
        end
    end

    assign frame_tick = frame_tick_reg;
`endif

    assign hsync    = hsync_reg;
    assign vsync    = vsync_reg;
    assign p_tick   = tick;
    assign pixel_x  = h_cnt;
    assign pixel_y  = v_cnt;
    assign video_on = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - directed table-driven bench for vga_sync (full and reduced timings)
module tb_vga_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_s;
    logic       hs_a, vs_a, von_a, pt_a;
    logic [9:0] x_a, y_a;
    logic       hs_s, vs_s, von_s, pt_s;
    logic [9:0] x_s, y_s;
`ifdef VGA_FRAME_TICK_EN
    logic       ft_a, ft_s;
`endif

    vga_sync dut_a (
        .clk      (clk),
        .reset    (reset_a),
        .hsync    (hs_a),
        .vsync    (vs_a),
        .video_on (von_a),
        .p_tick   (pt_a),
        .pixel_x  (x_a),
`ifdef VGA_FRAME_TICK_EN
        .frame_tick (ft_a),
`endif
        .pixel_y  (y_a)
    );

    // Reduced raster: H_TOTAL=15 (sync 10..12), V_TOTAL=11 (sync 8..9), 660 clks/frame.
    vga_sync #(
        .H_DISPLAY (8), .H_FP (2), .H_RETRACE (3), .H_BP (2),
        .V_DISPLAY (6), .V_FP (2), .V_RETRACE (2), .V_BP (1),
        .CLK_DIV   (4)
    ) dut_s (
        .clk      (clk),
        .reset    (reset_s),
        .hsync    (hs_s),
        .vsync    (vs_s),
        .video_on (von_s),
        .p_tick   (pt_s),
        .pixel_x  (x_s),
`ifdef VGA_FRAME_TICK_EN
        .frame_tick (ft_s),
`endif
        .pixel_y  (y_s)
    );

    typedef struct {
        int   k;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic von;
        logic pt;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_s[$];

    int checks   = 0;
    int failures = 0;
    int k_a = 0;
    int k_s = 0;
    int hs_low_a = 0;
    int ft_err_a = 0;
    int sweep_err_s = 0;
    int vs_low_s = 0;
    int vs_fall_cnt = 0;
    int vs_fall_k[2];
    int ft_cnt_s = 0;
    int ft_err_s = 0;
    logic prev_vs_s = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v, input logic [9:0] x, input logic [9:0] y,
                              input logic hs, input logic vs, input logic von, input logic pt);
        check({tag, ".pixel_x"}, 32'(x), 32'(v.x));
        check({tag, ".pixel_y"}, 32'(y), 32'(v.y));
        check({tag, ".hsync"}, 32'(hs), 32'(v.hs));
        check({tag, ".vsync"}, 32'(vs), 32'(v.vs));
        check({tag, ".video_on"}, 32'(von), 32'(v.von));
        check({tag, ".p_tick"}, 32'(pt), 32'(v.pt));
    endtask

    task automatic step_a();
        @(posedge clk);
        @(negedge clk);
        k_a++;
        if (k_a <= 3200 && hs_a === 1'b0) hs_low_a++;
`ifdef VGA_FRAME_TICK_EN
        if (ft_a !== 1'b0) ft_err_a++;
`endif
    endtask

    // Independent arithmetic reference for the reduced raster at k clks after release.
    task automatic sweep_s();
        int  ex, ey;
        logic ehs, evs, evon, ept;
        ex   = (k_s / 4) % 15;
        ey   = (k_s / 60) % 11;
        ept  = (k_s % 4) == 3;
        ehs  = !(ex >= 10 && ex <= 12);
        evs  = !(ey >= 8 && ey <= 9);
        evon = (ex < 8) && (ey < 6);
        if (32'(x_s) !== 32'(ex) || 32'(y_s) !== 32'(ey) || hs_s !== ehs ||
            vs_s !== evs || von_s !== evon || pt_s !== ept)
            sweep_err_s++;
        if (k_s > 0 && k_s <= 660 && vs_s === 1'b0) vs_low_s++;
        if (prev_vs_s === 1'b1 && vs_s === 1'b0) begin
            if (vs_fall_cnt < 2) vs_fall_k[vs_fall_cnt] = k_s;
            vs_fall_cnt++;
        end
        prev_vs_s = vs_s;
`ifdef VGA_FRAME_TICK_EN
        if (ft_s === 1'b1) ft_cnt_s++;
        if (ft_s !== ((k_s % 660) == 360)) ft_err_s++;
`endif
    endtask

    task automatic step_s();
        @(posedge clk);
        @(negedge clk);
        k_s++;
        sweep_s();
    endtask

    initial begin
        vec_t rv;
        // k, x, y, hs, vs, von, pt  (k = clk edges since reset release)
        tab_a.push_back('{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0});
        tab_a.push_back('{3,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1});
        tab_a.push_back('{4,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0});
        tab_a.push_back('{7,    1,   0, 1'b1, 1'b1, 1'b1, 1'b1});
        tab_a.push_back('{2559, 639, 0, 1'b1, 1'b1, 1'b1, 1'b1});
        tab_a.push_back('{2560, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0});
        tab_a.push_back('{2623, 655, 0, 1'b1, 1'b1, 1'b0, 1'b1});
        tab_a.push_back('{2624, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0});
        tab_a.push_back('{3007, 751, 0, 1'b0, 1'b1, 1'b0, 1'b1});
        tab_a.push_back('{3008, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0});
        tab_a.push_back('{3199, 799, 0, 1'b1, 1'b1, 1'b0, 1'b1});
        tab_a.push_back('{3200, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0});

        tab_s.push_back('{0,   0,  0,  1'b1, 1'b1, 1'b1, 1'b0});
        tab_s.push_back('{31,  7,  0,  1'b1, 1'b1, 1'b1, 1'b1});
        tab_s.push_back('{32,  8,  0,  1'b1, 1'b1, 1'b0, 1'b0});
        tab_s.push_back('{40,  10, 0,  1'b0, 1'b1, 1'b0, 1'b0});
        tab_s.push_back('{52,  13, 0,  1'b1, 1'b1, 1'b0, 1'b0});
        tab_s.push_back('{59,  14, 0,  1'b1, 1'b1, 1'b0, 1'b1});
        tab_s.push_back('{60,  0,  1,  1'b1, 1'b1, 1'b1, 1'b0});
        tab_s.push_back('{359, 14, 5,  1'b1, 1'b1, 1'b0, 1'b1});
        tab_s.push_back('{360, 0,  6,  1'b1, 1'b1, 1'b0, 1'b0});
        tab_s.push_back('{480, 0,  8,  1'b1, 1'b0, 1'b0, 1'b0});
        tab_s.push_back('{599, 14, 9,  1'b1, 1'b0, 1'b0, 1'b1});
        tab_s.push_back('{600, 0,  10, 1'b1, 1'b1, 1'b0, 1'b0});
        tab_s.push_back('{659, 14, 10, 1'b1, 1'b1, 1'b0, 1'b1});
        tab_s.push_back('{660, 0,  0,  1'b1, 1'b1, 1'b1, 1'b0});

        reset_a = 1'b1;
        reset_s = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        k_a = 0;

        foreach (tab_a[i]) begin
            while (k_a < tab_a[i].k) step_a();
            check_outs($sformatf("full_k%0d", tab_a[i].k), tab_a[i], x_a, y_a, hs_a, vs_a, von_a, pt_a);
        end
        check("full.hsync_low_clks", 32'(hs_low_a), 32'd384);

        // Reset on a p_tick cycle at (700,1) while hsync is low: reset wins over the tick.
        while (k_a < 6003) step_a();
        check("pre_reset.pixel_x", 32'(x_a), 32'd700);
        check("pre_reset.hsync", 32'(hs_a), 32'd0);
        check("pre_reset.p_tick", 32'(pt_a), 32'd1);
        reset_a = 1'b1;
        step_a();
        rv = '{0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        check_outs("mid_reset", rv, x_a, y_a, hs_a, vs_a, von_a, pt_a);
        step_a();
        step_a();
        check_outs("held_reset", rv, x_a, y_a, hs_a, vs_a, von_a, pt_a);
        reset_a = 1'b0;
        k_a = 0;
        repeat (3) step_a();
        check("post_reset.p_tick", 32'(pt_a), 32'd1);
        check("post_reset.pixel_x", 32'(x_a), 32'd0);
        step_a();
        check("post_reset.pixel_x_step", 32'(x_a), 32'd1);
`ifdef VGA_FRAME_TICK_EN
        check("full.frame_tick_quiet", 32'(ft_err_a), 32'd0);
`endif

        // Reduced raster: key points from the table plus a continuous reference sweep.
        reset_s = 1'b0;
        k_s = 0;
        sweep_s();
        foreach (tab_s[i]) begin
            while (k_s < tab_s[i].k) step_s();
            check_outs($sformatf("small_k%0d", tab_s[i].k), tab_s[i], x_s, y_s, hs_s, vs_s, von_s, pt_s);
        end
        while (k_s < 1400) step_s();
        check("small.sweep_errors", 32'(sweep_err_s), 32'd0);
        check("small.vsync_low_clks", 32'(vs_low_s), 32'd120);
        check("small.vsync_falls", 32'(vs_fall_cnt), 32'd2);
        if (vs_fall_cnt >= 2)
            check("small.frame_period", 32'(vs_fall_k[1] - vs_fall_k[0]), 32'd660);
`ifdef VGA_FRAME_TICK_EN
        check("small.frame_tick_count", 32'(ft_cnt_s), 32'd2);
        check("small.frame_tick_errors", 32'(ft_err_s), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
